// File: rtl/apb_bridge_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and transfer direction.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_t;

    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB3 bus between the bridge (master) and a single slave.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Converts level write/read requests into APB3 transfers with round-robin
// arbitration, slave-error reporting and an optional pready timeout.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                write_req,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   write_data,
    output logic                write_ack,
    input  logic                read_req,
    input  logic [ADDR_W-1:0]   read_addr,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_ack,
    output logic                resp_err,
    apb_master_bridge_if.master apb
);

    localparam int unsigned     CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    apb_state_t        state_q;
    logic              ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_q;
    logic              psel_q;
    logic              penable_q;
    logic              write_ack_q;
    logic              read_ack_q;
    logic [DATA_W-1:0] read_data_q;
    logic              resp_err_q;
    logic              grant_wr;

    // Write wins when it is alone or when the pointer favours it.
    assign grant_wr = write_req && (!read_req || ptr_q == DIR_WRITE);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            ptr_q       <= DIR_WRITE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            write_ack_q <= 1'b0;
            read_ack_q  <= 1'b0;
            read_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            write_ack_q <= 1'b0;
            read_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (write_req || read_req) begin
                        pwrite_q <= grant_wr;
                        paddr_q  <= grant_wr ? write_addr : read_addr;
                        if (grant_wr) pwdata_q <= write_data;
                        ptr_q    <= grant_wr ? DIR_READ : DIR_WRITE;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        resp_err_q  <= apb.pslverr;
                        if (!pwrite_q) read_data_q <= apb.prdata;
                        write_ack_q <= pwrite_q;
                        read_ack_q  <= !pwrite_q;
                        state_q     <= DONE;
                    end else if (TIMEOUT != 0) begin
                        // Counter ends at TIMEOUT on abort, so it never wraps.
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntLast) begin
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            resp_err_q  <= 1'b1;
                            if (!pwrite_q) read_data_q <= '0;
                            write_ack_q <= pwrite_q;
                            read_ack_q  <= !pwrite_q;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign write_ack   = write_ack_q;
    assign read_ack    = read_ack_q;
    assign read_data   = read_data_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: default, short-timeout and wide instances.
module tb_apb_master_bridge;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance: 8/8, TIMEOUT 16
    logic       wr_req0, rd_req0, wr_ack0, rd_ack0, err0;
    logic [7:0] wr_addr0, wr_data0, rd_addr0, rd_data0;
    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut0 (
        .pclk(pclk), .presetn(presetn),
        .write_req(wr_req0), .write_addr(wr_addr0), .write_data(wr_data0),
        .write_ack(wr_ack0), .read_req(rd_req0), .read_addr(rd_addr0),
        .read_data(rd_data0), .read_ack(rd_ack0), .resp_err(err0), .apb(bus0)
    );

    // Short timeout instance
    logic       wr_req4, rd_req4, wr_ack4, rd_ack4, err4;
    logic [7:0] wr_addr4, wr_data4, rd_addr4, rd_data4;
    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus4 ();
    apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut4 (
        .pclk(pclk), .presetn(presetn),
        .write_req(wr_req4), .write_addr(wr_addr4), .write_data(wr_data4),
        .write_ack(wr_ack4), .read_req(rd_req4), .read_addr(rd_addr4),
        .read_data(rd_data4), .read_ack(rd_ack4), .resp_err(err4), .apb(bus4)
    );

    // Wide instance: 16-bit address, 32-bit data
    logic        wr_reqw, rd_reqw, wr_ackw, rd_ackw, errw;
    logic [15:0] wr_addrw, rd_addrw;
    logic [31:0] wr_dataw, rd_dataw;
    apb_master_bridge_if #(.ADDR_W(16), .DATA_W(32)) busw ();
    apb_master_bridge #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(16)) dutw (
        .pclk(pclk), .presetn(presetn),
        .write_req(wr_reqw), .write_addr(wr_addrw), .write_data(wr_dataw),
        .write_ack(wr_ackw), .read_req(rd_reqw), .read_addr(rd_addrw),
        .read_data(rd_dataw), .read_ack(rd_ackw), .resp_err(errw), .apb(busw)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic test_reset;
        presetn = 1'b0;
        wr_req0 = 0; rd_req0 = 0; wr_addr0 = 0; wr_data0 = 0; rd_addr0 = 0;
        wr_req4 = 0; rd_req4 = 0; wr_addr4 = 0; wr_data4 = 0; rd_addr4 = 0;
        wr_reqw = 0; rd_reqw = 0; wr_addrw = 0; wr_dataw = 0; rd_addrw = 0;
        bus0.pready = 1; bus0.pslverr = 0; bus0.prdata = 8'h00;
        bus4.pready = 1; bus4.pslverr = 0; bus4.prdata = 8'h00;
        busw.pready = 1; busw.pslverr = 0; busw.prdata = 32'h0;
        cyc(2);
        n_checks++; if (bus0.psel !== 1'b0) begin n_fail++; $display("FAIL rst_psel got %0b want 0", bus0.psel); end
        n_checks++; if (bus0.penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable got %0b want 0", bus0.penable); end
        n_checks++; if (bus0.paddr !== 8'h00) begin n_fail++; $display("FAIL rst_paddr got %h want 00", bus0.paddr); end
        n_checks++; if (bus0.pwdata !== 8'h00) begin n_fail++; $display("FAIL rst_pwdata got %h want 00", bus0.pwdata); end
        n_checks++; if (bus0.pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite got %0b want 0", bus0.pwrite); end
        n_checks++; if (wr_ack0 !== 1'b0 || rd_ack0 !== 1'b0) begin n_fail++; $display("FAIL rst_acks got %0b%0b want 00", wr_ack0, rd_ack0); end
        n_checks++; if (rd_data0 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h want 00", rd_data0); end
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", err0); end
        n_checks++; if (busw.psel !== 1'b0 || busw.pwdata !== 32'h0) begin n_fail++; $display("FAIL rst_wide got psel=%0b pwdata=%h want 0/0", busw.psel, busw.pwdata); end
        presetn = 1'b1;
        cyc(1);
    endtask

    task automatic test_write;
        wr_addr0 = 8'hCC; wr_data0 = 8'hAC; bus0.pready = 1; bus0.pslverr = 0; wr_req0 = 1;
        cyc(1);
        n_checks++; if (bus0.psel !== 1'b1 || bus0.penable !== 1'b0) begin n_fail++; $display("FAIL wr_setup got psel=%0b pen=%0b want 1/0", bus0.psel, bus0.penable); end
        n_checks++; if (bus0.paddr !== 8'hCC || bus0.pwdata !== 8'hAC || bus0.pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_bus got %h/%h/%0b want CC/AC/1", bus0.paddr, bus0.pwdata, bus0.pwrite); end
        cyc(1);
        n_checks++; if (bus0.penable !== 1'b1 || bus0.psel !== 1'b1 || wr_ack0 !== 1'b0) begin n_fail++; $display("FAIL wr_access got pen=%0b psel=%0b ack=%0b want 1/1/0", bus0.penable, bus0.psel, wr_ack0); end
        cyc(1);
        n_checks++; if (wr_ack0 !== 1'b1 || err0 !== 1'b0 || bus0.psel !== 1'b0 || bus0.penable !== 1'b0) begin n_fail++; $display("FAIL wr_done got ack=%0b err=%0b psel=%0b pen=%0b want 1/0/0/0", wr_ack0, err0, bus0.psel, bus0.penable); end
        wr_req0 = 0;
        cyc(1);
        n_checks++; if (wr_ack0 !== 1'b0 || bus0.paddr !== 8'hCC || bus0.pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_after got ack=%0b paddr=%h pwrite=%0b want 0/CC/1", wr_ack0, bus0.paddr, bus0.pwrite); end
    endtask

    task automatic test_read_wait;
        rd_addr0 = 8'h55; bus0.pready = 0; bus0.prdata = 8'hFF; rd_req0 = 1;
        cyc(1);
        n_checks++; if (bus0.psel !== 1'b1 || bus0.pwrite !== 1'b0 || bus0.paddr !== 8'h55) begin n_fail++; $display("FAIL rd_setup got psel=%0b pwrite=%0b paddr=%h want 1/0/55", bus0.psel, bus0.pwrite, bus0.paddr); end
        cyc(1);
        n_checks++; if (bus0.penable !== 1'b1) begin n_fail++; $display("FAIL rd_access got pen=%0b want 1", bus0.penable); end
        cyc(1);
        n_checks++; if (rd_ack0 !== 1'b0 || bus0.penable !== 1'b1) begin n_fail++; $display("FAIL rd_wait1 got ack=%0b pen=%0b want 0/1", rd_ack0, bus0.penable); end
        cyc(1);
        n_checks++; if (rd_ack0 !== 1'b0 || bus0.penable !== 1'b1) begin n_fail++; $display("FAIL rd_wait2 got ack=%0b pen=%0b want 0/1", rd_ack0, bus0.penable); end
        bus0.pready = 1;
        cyc(1);
        n_checks++; if (rd_ack0 !== 1'b1 || rd_data0 !== 8'hFF || err0 !== 1'b0) begin n_fail++; $display("FAIL rd_done got ack=%0b data=%h err=%0b want 1/FF/0", rd_ack0, rd_data0, err0); end
        rd_req0 = 0;
        cyc(1);
        n_checks++; if (rd_ack0 !== 1'b0 || rd_data0 !== 8'hFF) begin n_fail++; $display("FAIL rd_hold got ack=%0b data=%h want 0/FF", rd_ack0, rd_data0); end
    endtask

    task automatic test_arbitration;
        presetn = 0; cyc(1); presetn = 1; cyc(1);
        wr_addr0 = 8'hF5; wr_data0 = 8'h50; rd_addr0 = 8'h55;
        bus0.prdata = 8'h3C; bus0.pready = 1; wr_req0 = 1; rd_req0 = 1;
        cyc(1);
        n_checks++; if (bus0.pwrite !== 1'b1 || bus0.paddr !== 8'hF5) begin n_fail++; $display("FAIL arb1_first got pwrite=%0b paddr=%h want 1/F5", bus0.pwrite, bus0.paddr); end
        cyc(2);
        n_checks++; if (wr_ack0 !== 1'b1 || rd_ack0 !== 1'b0) begin n_fail++; $display("FAIL arb1_wack got w=%0b r=%0b want 1/0", wr_ack0, rd_ack0); end
        wr_req0 = 0;
        cyc(2);
        n_checks++; if (bus0.psel !== 1'b1 || bus0.pwrite !== 1'b0 || bus0.paddr !== 8'h55) begin n_fail++; $display("FAIL arb1_second got psel=%0b pwrite=%0b paddr=%h want 1/0/55", bus0.psel, bus0.pwrite, bus0.paddr); end
        cyc(2);
        n_checks++; if (rd_ack0 !== 1'b1 || rd_data0 !== 8'h3C) begin n_fail++; $display("FAIL arb1_rack got ack=%0b data=%h want 1/3C", rd_ack0, rd_data0); end
        // Lone write moves the pointer to the read side
        rd_req0 = 0; wr_addr0 = 8'h01; wr_data0 = 8'h11; wr_req0 = 1;
        cyc(2);
        n_checks++; if (bus0.pwrite !== 1'b1 || bus0.paddr !== 8'h01) begin n_fail++; $display("FAIL arb_lone got pwrite=%0b paddr=%h want 1/01", bus0.pwrite, bus0.paddr); end
        cyc(2);
        wr_addr0 = 8'hF5; wr_data0 = 8'h50; rd_req0 = 1;
        cyc(2);
        n_checks++; if (bus0.pwrite !== 1'b0 || bus0.paddr !== 8'h55) begin n_fail++; $display("FAIL arb2_first got pwrite=%0b paddr=%h want 0/55", bus0.pwrite, bus0.paddr); end
        cyc(2);
        n_checks++; if (rd_ack0 !== 1'b1 || wr_ack0 !== 1'b0) begin n_fail++; $display("FAIL arb2_rack got r=%0b w=%0b want 1/0", rd_ack0, wr_ack0); end
        rd_req0 = 0;
        cyc(2);
        n_checks++; if (bus0.pwrite !== 1'b1 || bus0.paddr !== 8'hF5 || bus0.pwdata !== 8'h50) begin n_fail++; $display("FAIL arb2_second got pwrite=%0b paddr=%h pwdata=%h want 1/F5/50", bus0.pwrite, bus0.paddr, bus0.pwdata); end
        cyc(2);
        n_checks++; if (wr_ack0 !== 1'b1) begin n_fail++; $display("FAIL arb2_wack got %0b want 1", wr_ack0); end
        wr_req0 = 0;
        cyc(1);
    endtask

    task automatic test_slverr;
        wr_addr0 = 8'h10; wr_data0 = 8'h5A; bus0.pready = 1; bus0.pslverr = 1; wr_req0 = 1;
        cyc(3);
        n_checks++; if (wr_ack0 !== 1'b1 || err0 !== 1'b1) begin n_fail++; $display("FAIL err_set got ack=%0b err=%0b want 1/1", wr_ack0, err0); end
        bus0.pslverr = 0; wr_addr0 = 8'h11;
        cyc(4);
        n_checks++; if (wr_ack0 !== 1'b1 || err0 !== 1'b0 || bus0.paddr !== 8'h11) begin n_fail++; $display("FAIL err_clear got ack=%0b err=%0b paddr=%h want 1/0/11", wr_ack0, err0, bus0.paddr); end
        wr_req0 = 0;
        cyc(1);
    endtask

    task automatic test_timeout;
        rd_addr4 = 8'h20; bus4.prdata = 8'hA5; bus4.pready = 1; rd_req4 = 1;
        cyc(3);
        n_checks++; if (rd_ack4 !== 1'b1 || rd_data4 !== 8'hA5 || err4 !== 1'b0) begin n_fail++; $display("FAIL to_clean got ack=%0b data=%h err=%0b want 1/A5/0", rd_ack4, rd_data4, err4); end
        rd_addr4 = 8'h21; bus4.pready = 0;
        cyc(2);
        n_checks++; if (bus4.psel !== 1'b1 || bus4.penable !== 1'b0 || bus4.paddr !== 8'h21) begin n_fail++; $display("FAIL to_setup got psel=%0b pen=%0b paddr=%h want 1/0/21", bus4.psel, bus4.penable, bus4.paddr); end
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            n_checks++; if (bus4.penable !== 1'b1 || rd_ack4 !== 1'b0) begin n_fail++; $display("FAIL to_access%0d got pen=%0b ack=%0b want 1/0", i, bus4.penable, rd_ack4); end
        end
        cyc(1);
        n_checks++; if (rd_ack4 !== 1'b1 || err4 !== 1'b1 || rd_data4 !== 8'h00 || bus4.psel !== 1'b0 || bus4.penable !== 1'b0) begin n_fail++; $display("FAIL to_abort got ack=%0b err=%0b data=%h psel=%0b pen=%0b want 1/1/00/0/0", rd_ack4, err4, rd_data4, bus4.psel, bus4.penable); end
        rd_req4 = 0;
        cyc(1);
        n_checks++; if (rd_ack4 !== 1'b0) begin n_fail++; $display("FAIL to_ackpulse got %0b want 0", rd_ack4); end
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        wr_addr0 = 8'h77; wr_data0 = 8'h33; bus0.pready = 0; wr_req0 = 1;
        cyc(2);
        n_checks++; if (bus0.penable !== 1'b1) begin n_fail++; $display("FAIL mid_access got pen=%0b want 1", bus0.penable); end
        #2 presetn = 0;
        #1;
        n_checks++; if (bus0.psel !== 1'b0 || bus0.penable !== 1'b0 || wr_ack0 !== 1'b0 || rd_ack0 !== 1'b0) begin n_fail++; $display("FAIL mid_drop got psel=%0b pen=%0b w=%0b r=%0b want 0/0/0/0", bus0.psel, bus0.penable, wr_ack0, rd_ack0); end
        #2;
        wr_req0 = 0; bus0.pready = 1; presetn = 1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (wr_ack0 === 1'b1 || rd_ack0 === 1'b1 || bus0.psel === 1'b1) acks++;
        end
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL mid_noack got %0d active cycles want 0", acks); end
    endtask

    task automatic test_wide;
        wr_addrw = 16'hBEEF; wr_dataw = 32'hDEADBEEF; busw.pready = 1; wr_reqw = 1;
        cyc(1);
        n_checks++; if (busw.psel !== 1'b1 || busw.paddr !== 16'hBEEF || busw.pwdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL w_wr_setup got psel=%0b paddr=%h pwdata=%h want 1/BEEF/DEADBEEF", busw.psel, busw.paddr, busw.pwdata); end
        cyc(1);
        n_checks++; if (busw.penable !== 1'b1) begin n_fail++; $display("FAIL w_wr_access got %0b want 1", busw.penable); end
        cyc(1);
        n_checks++; if (wr_ackw !== 1'b1 || errw !== 1'b0) begin n_fail++; $display("FAIL w_wr_done got ack=%0b err=%0b want 1/0", wr_ackw, errw); end
        wr_reqw = 0;
        cyc(1);
        rd_addrw = 16'h1234; busw.prdata = 32'hCAFEF00D; busw.pready = 0; rd_reqw = 1;
        cyc(1);
        n_checks++; if (busw.pwrite !== 1'b0 || busw.paddr !== 16'h1234) begin n_fail++; $display("FAIL w_rd_setup got pwrite=%0b paddr=%h want 0/1234", busw.pwrite, busw.paddr); end
        cyc(3);
        n_checks++; if (rd_ackw !== 1'b0 || busw.penable !== 1'b1) begin n_fail++; $display("FAIL w_rd_wait got ack=%0b pen=%0b want 0/1", rd_ackw, busw.penable); end
        busw.pready = 1;
        cyc(1);
        n_checks++; if (rd_ackw !== 1'b1 || rd_dataw !== 32'hCAFEF00D || errw !== 1'b0) begin n_fail++; $display("FAIL w_rd_done got ack=%0b data=%h err=%0b want 1/CAFEF00D/0", rd_ackw, rd_dataw, errw); end
        rd_reqw = 0;
        cyc(1);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_wait;
        test_arbitration;
        test_slverr;
        test_timeout;
        test_reset_mid;
        test_wide;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
